dtmf_tone_decoder: RTL and testbench
====================================

Name: dtmf_tone_decoder

Overview:
Receive-side counterpart of the DTMF tone generators. It measures the period of two digitized square-wave tones, one row tone and one column tone, against the 1 MHz system clock. Each tone is classified into one of the four standard row or four standard column frequencies. Once both channels are stable, the block reports the pressed key as a 4-bit code with a valid level and a one-cycle strobe. It sits between the comparator/limiter outputs of the analog front end and the Nios-facing key register.

Parameters:
TOL, 20, acceptance half-window in inclk cycles around each nominal period
CONFIRM, 4, consecutive in-window periods of the same tone required to lock a channel
TIMEOUT, 2047, cycles without a rising edge before a channel is declared silent (must be < 4095)

Ports:
inclk  input  1  1 MHz system clock; all logic on posedge
rst_n  input  1  synchronous active-low reset
row_in  input  1  asynchronous row-tone square wave
col_in  input  1  asynchronous column-tone square wave
key_code  output  4  {row_idx[1:0], col_idx[1:0]}
key_valid  output  1  high while a key is locked
key_strobe  output  1  one-cycle pulse when a new key locks
err_flag  output  1  sticky; set on an out-of-window period after lock; cleared only by reset

Behaviour:
- Reset: rst_n sampled low on a posedge clears all state. key_code=0, key_valid=0, key_strobe=0, err_flag=0. Counters, sync flops and channel FSMs return to IDLE.
- Synchronisers:
  - Each input passes through a 2-flop synchronizer plus an edge-detect flop.
  - A rising edge is a synced 0->1. Edge-to-counter latency is 3 cycles, identical on both channels.
- Per-channel period counter:
  - 12 bits, increments every cycle and saturates at 4095.
  - On a rising edge, the count is captured as the measured period and the counter reloads to 1.
- Nominal periods (cycles):
  - Rows: 697 Hz=1435 (idx0), 770 Hz=1299 (idx1), 852 Hz=1174 (idx2), 941 Hz=1063 (idx3).
  - Columns: 1209 Hz=827 (idx0), 1336 Hz=749 (idx1), 1477 Hz=677 (idx2), 1633 Hz=612 (idx3).
- Classification:
  - A period P matches index i if |P - nominal_i| <= TOL (inclusive at both ends).
  - No match = miss. Windows must not overlap; this is checked by assertion at elaboration.
- Channel FSM (IDLE, MEASURE, LOCKED), per channel:
  - IDLE: the first rising edge only starts the counter (no period captured) -> MEASURE with match_cnt=0.
  - MEASURE, on each captured period:
    - Match to the same index as the previous period: match_cnt++.
    - Match to a different index: cand_idx=new, match_cnt=1.
    - Miss: match_cnt=0.
    - When match_cnt reaches CONFIRM -> LOCKED with lock_idx=cand_idx.
  - LOCKED: a captured period matching lock_idx stays LOCKED. A miss or a different index -> MEASURE with match_cnt=0 and sets err_flag.
  - Any state: counter reaches TIMEOUT with no edge -> IDLE. No err_flag for this case; it is silence.
- Key logic:
  - key_valid = both channels LOCKED (registered, 1 cycle after the later lock).
  - On the key_valid 0->1 transition: key_code loads {row lock_idx, col lock_idx} and key_strobe pulses high for exactly one cycle, coincident with key_valid rising.
  - key_code holds its last value after key_valid falls.
  - If either channel leaves LOCKED, key_valid drops the next cycle.
  - If both channels re-lock to a different key without key_valid falling in between (impossible by construction), no special case is needed.
- Simultaneous events: an edge and a TIMEOUT reached on the same cycle are treated as an edge; the period is captured. Row and column events are fully independent.
- Reset mid-tone: everything returns to IDLE. The first post-reset edge is not measured.
- Key mapping for software (informational): codes 0..15 = 1,2,3,A,4,5,6,B,7,8,9,C,*,0,#,D.

Test Plan:
- Reset with both inputs toggling -> all outputs 0 throughout reset. key_valid=0 until CONFIRM+1 edges per channel after release.
- Row 1435-cycle square wave, column 827-cycle -> key_valid rises after the 5th column edge / 5th row edge (whichever is later) +1 cycle. key_code=0x0 ("1"). key_strobe high exactly 1 cycle.
- Row 1063, column 612 -> key_code=0xF ("D"). Repeat with periods 1063±20 and 612±20 -> still lock. Periods 1063±21 -> never lock.
- Lock on 0x5, then stop column toggling -> key_valid falls at TIMEOUT+1 cycles after the last synced column edge. err_flag stays 0. key_code still 0x5.
- Lock on 0x5, then inject one column period of 700 -> key_valid falls, err_flag=1. After 4 more good periods, key_valid and key_strobe reassert with key_code=0x5.
- Alternating column periods 749/677 -> no lock; key_valid stays 0 indefinitely.

Source files
------------

// File: rtl/dtmf_tone_decoder.sv
// DTMF receive decoder: measures the row and column square-wave periods,
// classifies each into one of four tones and reports the locked key.
module dtmf_channel #(
   parameter logic [3:0][11:0] NOM     = '0,
   parameter int               TOL     = 20,
   parameter int               CONFIRM = 4,
   parameter int               TIMEOUT = 2047
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tone,
   output logic       locked,
   output logic [1:0] lock_idx,
   output logic       bad
);
   localparam int CW = $clog2(CONFIRM + 1);
   localparam logic [CW-1:0] CONF = CW'(CONFIRM);

   typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
   state_t        state, state_nx;
   logic [2:0]    sync;
   logic [11:0]   cnt;
   logic [CW-1:0] match_cnt, match_nx;
   logic [1:0]    cand, idx;
   logic          rise, hit, expired;

   assign rise    = sync[1] & ~sync[2];
   // an edge on the timeout cycle wins and is measured
   assign expired = (cnt == 12'(TIMEOUT)) & ~rise;

   always_comb begin
      hit = 1'b0;
      idx = 2'd0;
      for (int i = 0; i < 4; i++)
         if (int'(cnt) >= int'(NOM[i]) - TOL && int'(cnt) <= int'(NOM[i]) + TOL) begin
            hit = 1'b1;
            idx = 2'(i);
         end
   end

   always_comb begin
      if (!hit)                                 match_nx = '0;
      else if (match_cnt != '0 && idx == cand)  match_nx = match_cnt + 1'b1;
      else                                      match_nx = CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (rise) state_nx = MEASURE;
         MEASURE: if (expired) state_nx = IDLE;
                  else if (rise && match_nx == CONF) state_nx = LOCKED;
         LOCKED:  if (expired) state_nx = IDLE;
                  else if (rise && (!hit || idx != lock_idx)) state_nx = MEASURE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      locked = (state == LOCKED);
      bad    = (state == LOCKED) && rise && (!hit || idx != lock_idx);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync      <= '0;
         cnt       <= '0;
         match_cnt <= '0;
         cand      <= '0;
         lock_idx  <= '0;
      end else begin
         sync <= {sync[1:0], tone};
         if (rise)                         cnt <= 12'd1;
         else if (state == IDLE || expired) cnt <= '0;
         else if (cnt != '1)               cnt <= cnt + 12'd1;
         if (rise) begin
            if (state == MEASURE) begin
               match_cnt <= match_nx;
               if (hit) cand <= idx;
               if (match_nx == CONF) lock_idx <= idx;
            end else begin
               match_cnt <= '0;
            end
         end
      end
   end
endmodule

module dtmf_tone_decoder #(
   parameter int TOL     = 20,
   parameter int CONFIRM = 4,
   parameter int TIMEOUT = 2047
) (
   input  logic       inclk,
   input  logic       rst_n,
   input  logic       row_in,
   input  logic       col_in,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_strobe,
   output logic       err_flag
);
   localparam logic [3:0][11:0] ROW_NOM = {12'd1063, 12'd1174, 12'd1299, 12'd1435};
   localparam logic [3:0][11:0] COL_NOM = {12'd612, 12'd677, 12'd749, 12'd827};
   localparam logic [1:0][3:0][11:0] NOM = {COL_NOM, ROW_NOM};

   function automatic bit windows_ok(input logic [3:0][11:0] t);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (i != j && int'(t[i]) - int'(t[j]) >= 0 && int'(t[i]) - int'(t[j]) <= 2 * TOL)
               return 1'b0;
      return 1'b1;
   endfunction

   if (!windows_ok(ROW_NOM) || !windows_ok(COL_NOM) || TIMEOUT >= 4095 || CONFIRM < 1) begin : g_cfg_err
      $error("dtmf_tone_decoder: overlapping tone windows or bad TIMEOUT/CONFIRM");
   end

   logic [1:0]      tones, locked, bad;
   logic [1:0][1:0] idx;
   logic            both;

   assign tones = {col_in, row_in};

   for (genvar g = 0; g < 2; g++) begin : g_ch
      dtmf_channel #(
         .NOM(NOM[g]), .TOL(TOL), .CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT)
      ) u_ch (
         .clk(inclk), .rst_n(rst_n), .tone(tones[g]),
         .locked(locked[g]), .lock_idx(idx[g]), .bad(bad[g])
      );
   end

   assign both = &locked;

   always_ff @(posedge inclk) begin
      if (!rst_n) begin
         key_code   <= '0;
         key_valid  <= 1'b0;
         key_strobe <= 1'b0;
         err_flag   <= 1'b0;
      end else begin
         key_valid  <= both;
         key_strobe <= both & ~key_valid;
         if (both & ~key_valid) key_code <= {idx[0], idx[1]};
         if (|bad) err_flag <= 1'b1;
      end
   end
endmodule

// File: tb/tb_dtmf_tone_decoder.sv
// Randomized bench: drives row/column tones from period lists and compares key
// events against a period-list model of lock/unlock behaviour.
module tb_dtmf_tone_decoder;
   localparam int TOL = 20, CONFIRM = 4, TIMEOUT = 2047, LAT = 4;

   logic       inclk = 1'b0, rst_n = 1'b0, row_in = 1'b0, col_in = 1'b0;
   logic [3:0] key_code;
   logic       key_valid, key_strobe, err_flag;

   dtmf_tone_decoder #(.TOL(TOL), .CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT)) dut (
      .inclk(inclk), .rst_n(rst_n), .row_in(row_in), .col_in(col_in),
      .key_code(key_code), .key_valid(key_valid), .key_strobe(key_strobe), .err_flag(err_flag)
   );

   initial forever #500 inclk = ~inclk;

   int checks = 0, fails = 0;
   int row_nom[4] = '{1435, 1299, 1174, 1063};
   int col_nom[4] = '{827, 749, 677, 612};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // tone drivers: each queue entry is one full period, rising edge first
   bit noise = 1'b0;
   int row_q[$], col_q[$], row_rise[$], col_rise[$];
   int r_p = 0, r_pos = 0, c_p = 0, c_pos = 0;

   initial begin
      int now;
      forever begin
         @(negedge inclk);
         now = int'($time / 1000);
         if (noise) begin
            row_in = 1'($urandom_range(0, 1));
            col_in = 1'($urandom_range(0, 1));
            r_p = 0;
            c_p = 0;
         end else begin
            if (r_p != 0) begin r_pos++; if (r_pos == r_p) r_p = 0; end
            if (r_p == 0 && row_q.size() > 0) begin
               r_p = row_q.pop_front(); r_pos = 0; row_rise.push_back(now);
            end
            row_in = (r_p != 0) && (r_pos < r_p / 2);
            if (c_p != 0) begin c_pos++; if (c_pos == c_p) c_p = 0; end
            if (c_p == 0 && col_q.size() > 0) begin
               c_p = col_q.pop_front(); c_pos = 0; col_rise.push_back(now);
            end
            col_in = (c_p != 0) && (c_pos < c_p / 2);
         end
      end
   end

   // output monitor
   bit chk_rst = 1'b0, prev_valid = 1'b0;
   int rst_bad = 0;
   int rise_t[$], rise_code[$], fall_t[$], strobe_t[$];

   initial begin
      int now;
      forever begin
         @(negedge inclk);
         now = int'($time / 1000);
         if (chk_rst && (key_valid !== 1'b0 || key_strobe !== 1'b0 || err_flag !== 1'b0 || key_code !== 4'd0))
            rst_bad++;
         if (key_valid === 1'b1 && !prev_valid) begin rise_t.push_back(now); rise_code.push_back(int'(key_code)); end
         if (key_valid !== 1'b1 && prev_valid) fall_t.push_back(now);
         if (key_strobe === 1'b1) strobe_t.push_back(now);
         prev_valid = (key_valid === 1'b1);
      end
   end

   // reference model: lock intervals per channel from the driven rise times
   int ls[2][8], le[2][8], li[2][8], nl[2];
   bit exp_err;

   function automatic int classify(input int ch, input int p);
      for (int i = 0; i < 4; i++) begin
         int n;
         n = (ch == 0) ? row_nom[i] : col_nom[i];
         if (p >= n - TOL && p <= n + TOL) return i;
      end
      return -1;
   endfunction

   task automatic model_chan(input int ch);
      int r[$];
      int streak, cand, lk, c;
      if (ch == 0) r = row_rise; else r = col_rise;
      nl[ch] = 0; streak = 0; cand = -1; lk = -1;
      for (int k = 1; k < r.size(); k++) begin
         c = classify(ch, r[k] - r[k-1]);
         if (lk >= 0) begin
            if (c != lk) begin le[ch][nl[ch]-1] = r[k]; lk = -1; streak = 0; exp_err = 1'b1; end
         end else if (c < 0) begin
            streak = 0;
         end else begin
            if (streak > 0 && c == cand) streak++;
            else begin cand = c; streak = 1; end
            if (streak == CONFIRM && nl[ch] < 8) begin
               lk = c; ls[ch][nl[ch]] = r[k]; li[ch][nl[ch]] = c; nl[ch]++;
            end
         end
      end
      if (lk >= 0) le[ch][nl[ch]-1] = r[r.size()-1] + TIMEOUT;
   endtask

   task automatic do_reset();
      rst_bad = 0;
      noise = 1'b1;
      rst_n = 1'b0;
      @(negedge inclk);
      chk_rst = 1'b1;
      repeat (30) @(negedge inclk);
      chk_rst = 1'b0;
      noise = 1'b0;
      repeat (5) @(negedge inclk);
      rst_n = 1'b1;
      repeat (3) @(negedge inclk);
      rise_t.delete(); rise_code.delete(); fall_t.delete(); strobe_t.delete();
      row_rise.delete(); col_rise.delete();
   endtask

   task automatic fill(input int ch, input int nom, input int n, input int mode);
      int p;
      for (int k = 0; k < n; k++) begin
         case (mode)
            0:       p = nom + int'($urandom_range(0, 2 * TOL)) - TOL;
            1:       p = nom + ((k % 2) ? TOL : -TOL);
            2:       p = nom + ((k % 2) ? TOL + 1 : -(TOL + 1));
            default: p = nom;
         endcase
         if (ch == 0) row_q.push_back(p); else col_q.push_back(p);
      end
   endtask

   task automatic run(input string tag);
      bit idle;
      int exp_r[$], exp_f[$];
      int s, e, last_code;
      chk({tag, ".rst"}, rst_bad, 0);
      idle = 1'b0;
      for (int i = 0; i < 30000 && !idle; i++) begin
         @(negedge inclk);
         idle = row_q.size() == 0 && col_q.size() == 0 && r_p == 0 && c_p == 0;
      end
      chk({tag, ".drained"}, 32'(idle), 1);
      repeat (TIMEOUT + 20) @(negedge inclk);
      exp_err = 1'b0;
      model_chan(0);
      model_chan(1);
      for (int i = 0; i < nl[0]; i++)
         for (int j = 0; j < nl[1]; j++) begin
            s = (ls[0][i] > ls[1][j]) ? ls[0][i] : ls[1][j];
            e = (le[0][i] < le[1][j]) ? le[0][i] : le[1][j];
            if (s < e) begin
               exp_r.push_back((s + LAT) * 16 + li[0][i] * 4 + li[1][j]);
               exp_f.push_back(e + LAT);
            end
         end
      exp_r.sort();
      exp_f.sort();
      chk({tag, ".n_rise"}, rise_t.size(), exp_r.size());
      chk({tag, ".n_strobe"}, strobe_t.size(), exp_r.size());
      chk({tag, ".n_fall"}, fall_t.size(), exp_f.size());
      for (int i = 0; i < exp_r.size() && i < rise_t.size(); i++) begin
         chk($sformatf("%s.rise_t%0d", tag, i), rise_t[i], exp_r[i] / 16);
         chk($sformatf("%s.code%0d", tag, i), rise_code[i], exp_r[i] % 16);
      end
      for (int i = 0; i < exp_r.size() && i < strobe_t.size(); i++)
         chk($sformatf("%s.strobe_t%0d", tag, i), strobe_t[i], exp_r[i] / 16);
      for (int i = 0; i < exp_f.size() && i < fall_t.size(); i++)
         chk($sformatf("%s.fall_t%0d", tag, i), fall_t[i], exp_f[i]);
      last_code = (exp_r.size() > 0) ? exp_r[exp_r.size()-1] % 16 : 0;
      chk({tag, ".code_hold"}, 32'(key_code), last_code);
      chk({tag, ".err"}, 32'(err_flag), 32'(exp_err));
   endtask

   initial begin
      int ri, ci, n, sum;

      do_reset();
      fill(0, 1435, 6, 0); fill(1, 827, 11, 0);
      run("key1");

      do_reset();
      fill(0, 1063, 6, 1); fill(1, 612, 11, 1);
      run("keyD_edge");

      do_reset();
      fill(0, 1063, 6, 2); fill(1, 612, 11, 2);
      run("keyD_out");

      do_reset();
      fill(0, 1299, 12, 3);
      fill(1, 749, 9, 3); col_q.push_back(700); fill(1, 749, 5, 3);
      run("key5_err");

      do_reset();
      fill(0, 1174, 6, 0);
      for (int k = 0; k < 11; k++) col_q.push_back((k % 2) ? 677 : 749);
      run("alt");

      for (int t = 0; t < 2; t++) begin
         do_reset();
         ri = int'($urandom_range(0, 3));
         ci = int'($urandom_range(0, 3));
         fill(0, row_nom[ri], 6, 0);
         sum = 0;
         foreach (row_q[k]) sum += row_q[k];
         n = sum / col_nom[ci] + 2;
         fill(1, col_nom[ci], n, 0);
         if ($urandom_range(0, 1) == 1)
            col_q[$urandom_range(2, n - 2)] = col_nom[ci] + TOL + 1 + int'($urandom_range(0, 20));
         run($sformatf("rand%0d", t));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
